// File: rtl/video_squ_gen_pkg.sv
// Shared definitions for the square-LED composite video generator.
// Holds line/field timing constants, region bounds, mode encodings, grid
// geometry, the pipeline stage structures and the chroma sine table.
package video_squ_gen_pkg;

    // line / field timing
    localparam int H_TOTAL      = 780;
    localparam int V_TOTAL_EVEN = 263;
    localparam int V_TOTAL_ODD  = 262;

    // horizontal regions (inclusive bounds)
    localparam int H_SYNC_END  = 57;
    localparam int H_BURST_BEG = 66;
    localparam int H_BURST_END = 96;
    localparam int H_ACT_BEG   = 128;
    localparam int H_ACT_END   = 767;

    // vertical regions (inclusive bounds)
    localparam int V_ACT_END   = 239;
    localparam int V_VSYNC_BEG = 244;
    localparam int V_VSYNC_END = 246;
    localparam int H_VSYNC_END = 721;

    // subcarrier: 7/24 cycle per clock, eight phases of three steps each
    localparam int ACC_MOD  = 24;
    localparam int ACC_STEP = 7;

    // LED grid geometry in pixel coordinates
    localparam int GRID_COLS = 6;
    localparam int GRID_X0   = 16;
    localparam int GRID_Y0   = 24;
    localparam int GRID_DX   = 48;
    localparam int GRID_DY   = 64;
    localparam int SQ_W      = 40;
    localparam int SQ_H      = 56;

    localparam int BAR_W = 40;

    typedef enum logic [1:0] {
        MODE_GRID  = 2'd0,
        MODE_RAMP  = 2'd1,
        MODE_BARS  = 2'd2,
        MODE_BLANK = 2'd3
    } mode_e;

    // stage 1: region / pixel decode
    typedef struct packed {
        logic       sync;
        logic       burst;
        logic       active;
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] cph;
        mode_e      mode;
        logic [7:0] fctr;
    } st1_t;

    // stage 2: LED hit, palette entry, pattern indices
    typedef struct packed {
        logic       sync;
        logic       burst;
        logic       active;
        logic [2:0] cph;
        mode_e      mode;
        logic       hit;
        logic [3:0] pal;
        logic [2:0] ramp;
        logic [2:0] bar;
    } st2_t;

    // Signed chroma sample; half-amplitude entries truncate toward zero.
    function automatic int sin_lut(input logic [2:0] ph, input int amp);
        case (ph)
            3'd0, 3'd3: return amp / 2;
            3'd1, 3'd2: return amp;
            3'd4, 3'd7: return -(amp / 2);
            default:    return -amp;
        endcase
    endfunction

    function automatic logic in_square(input logic [8:0] x, input logic [7:0] y, input int n);
        int x0;
        int y0;
        x0 = GRID_X0 + GRID_DX * (n % GRID_COLS);
        y0 = GRID_Y0 + GRID_DY * (n / GRID_COLS);
        return (int'(x) >= x0) && (int'(x) < x0 + SQ_W) &&
               (int'(y) >= y0) && (int'(y) < y0 + SQ_H);
    endfunction

endpackage

// File: rtl/video_squ_tg.sv
// Timing generator: line/field/frame counters, subcarrier accumulator and
// region decode for the composite video generator.
// Ports:
//   CK_i, RST_i, CK_EE_i   clock, sync active-high reset, clock enable
//   fctr_o                 field counter
//   cph_o                  subcarrier phase 0..7
//   sync_o/burst_o/active_o region flags for the current counter position
//   x_o, y_o               pixel coordinates (valid while active_o)
//   hvcy_o                 last active pixel of the field, qualified by CK_EE_i
module video_squ_tg
    import video_squ_gen_pkg::*;
#(
    parameter int C_INTERLACE = 0
) (
    input  logic       CK_i,
    input  logic       RST_i,
    input  logic       CK_EE_i,
    output logic [7:0] fctr_o,
    output logic [2:0] cph_o,
    output logic       sync_o,
    output logic       burst_o,
    output logic       active_o,
    output logic [8:0] x_o,
    output logic [7:0] y_o,
    output logic       hvcy_o
);

    logic [9:0] hctr_q, hctr_d;
    logic [8:0] vctr_q, vctr_d;
    logic [7:0] fctr_q, fctr_d;
    logic [4:0] acc_q, acc_d;
    logic [8:0] vlast;
    logic       vsync_line;

    always_comb begin
        // odd fields are one line short when interlaced
        vlast  = (C_INTERLACE != 0 && fctr_q[0]) ? 9'(V_TOTAL_ODD - 1) : 9'(V_TOTAL_EVEN - 1);
        hctr_d = hctr_q + 10'd1;
        vctr_d = vctr_q;
        fctr_d = fctr_q;
        if (hctr_q == 10'(H_TOTAL - 1)) begin
            hctr_d = '0;
            if (vctr_q == vlast) begin
                vctr_d = '0;
                fctr_d = fctr_q + 8'd1;
            end else begin
                vctr_d = vctr_q + 9'd1;
            end
        end
        if (acc_q >= 5'(ACC_MOD - ACC_STEP)) begin
            acc_d = acc_q - 5'(ACC_MOD - ACC_STEP);
        end else begin
            acc_d = acc_q + 5'(ACC_STEP);
        end
    end

    always_ff @(posedge CK_i) begin
        if (RST_i) begin
            hctr_q <= '0;
            vctr_q <= '0;
            fctr_q <= '0;
            acc_q  <= '0;
        end else if (CK_EE_i) begin
            hctr_q <= hctr_d;
            vctr_q <= vctr_d;
            fctr_q <= fctr_d;
            acc_q  <= acc_d;
        end
    end

    always_comb begin
        vsync_line = (vctr_q >= 9'(V_VSYNC_BEG)) && (vctr_q <= 9'(V_VSYNC_END));
        // vertical sync lines carry broad pulses instead of the normal tip
        sync_o     = vsync_line ? (hctr_q <= 10'(H_VSYNC_END)) : (hctr_q <= 10'(H_SYNC_END));
        burst_o    = (hctr_q >= 10'(H_BURST_BEG)) && (hctr_q <= 10'(H_BURST_END));
        active_o   = (hctr_q >= 10'(H_ACT_BEG)) && (hctr_q <= 10'(H_ACT_END)) &&
                     (vctr_q <= 9'(V_ACT_END));
        x_o        = 9'((hctr_q - 10'(H_ACT_BEG)) >> 1);
        y_o        = vctr_q[7:0];
        cph_o      = 3'(acc_q / 5'd3);
        fctr_o     = fctr_q;
        hvcy_o     = (vctr_q == 9'(V_ACT_END)) && (hctr_q == 10'(H_ACT_END)) && CK_EE_i;
    end

endmodule

// File: rtl/video_squ_gen.sv
// Composite video generator for a resistor-ladder DAC: LED square grid with
// per-LED colour palette, moving ramp and colour bar test patterns.
// Ports:
//   CK_i, RST_i, CK_EE_i   clock, sync active-high reset, clock enable
//   LEDs_ON_i              LED on/off levels
//   MODE_i                 0 grid, 1 ramp, 2 colour bars, 3 blank
//   PAL_WE_i/As/Ds         palette write port, data {chroma_on, phase[2:0]}
//   VIDEOs_o               composite sample (4 enabled clocks behind counters)
//   HVcy_o                 last active pixel of the field (from counters)
//   FCTRs_o                field counter
module video_squ_gen
    import video_squ_gen_pkg::*;
#(
    parameter int C_DAC_W        = 5,
    parameter int C_LED_N        = 18,
    parameter int C_PEDE         = 12,
    parameter int C_WHITE        = 30,
    parameter int C_CAMP         = 6,
    parameter int C_INTERLACE    = 0,
    parameter int C_XCBURST_SHUF = 0
) (
    input  logic               CK_i,
    input  logic               RST_i,
    input  logic               CK_EE_i,
    input  logic [C_LED_N-1:0] LEDs_ON_i,
    input  logic [1:0]         MODE_i,
    input  logic               PAL_WE_i,
    input  logic [4:0]         PAL_As_i,
    input  logic [3:0]         PAL_Ds_i,
    output logic [C_DAC_W-1:0] VIDEOs_o,
    output logic               HVcy_o,
    output logic [7:0]         FCTRs_o
);

    localparam int SW        = C_DAC_W + 2;
    localparam int BURST_OFS = (C_XCBURST_SHUF != 0) ? 0 : 4;

    logic [7:0] tg_fctr;
    logic [2:0] tg_cph;
    logic       tg_sync, tg_burst, tg_active;
    logic [8:0] tg_x;
    logic [7:0] tg_y;

    st1_t                      s1_q, s1_d;
    logic [C_LED_N-1:0]        leds_q, leds_d;
    st2_t                      s2_q, s2_d;
    logic [SW-1:0]             luma_q, luma_d;
    logic signed [SW-1:0]      chroma_q, chroma_d;
    logic [C_DAC_W-1:0]        video_q, video_d;
    logic [3:0]                pal_q [C_LED_N];
    logic [3:0]                pal_d [C_LED_N];
    logic signed [SW-1:0]      sum_s;

    video_squ_tg #(
        .C_INTERLACE (C_INTERLACE)
    ) u_tg (
        .CK_i     (CK_i),
        .RST_i    (RST_i),
        .CK_EE_i  (CK_EE_i),
        .fctr_o   (tg_fctr),
        .cph_o    (tg_cph),
        .sync_o   (tg_sync),
        .burst_o  (tg_burst),
        .active_o (tg_active),
        .x_o      (tg_x),
        .y_o      (tg_y),
        .hvcy_o   (HVcy_o)
    );

    // palette: out-of-range indices match no entry and are dropped
    always_comb begin
        for (int n = 0; n < C_LED_N; n++) begin
            pal_d[n] = pal_q[n];
            if (PAL_WE_i && (PAL_As_i == 5'(n))) begin
                pal_d[n] = PAL_Ds_i;
            end
        end
    end

    // stage 1: region and pixel decode, inputs sampled
    always_comb begin
        s1_d.sync   = tg_sync;
        s1_d.burst  = tg_burst;
        s1_d.active = tg_active;
        s1_d.x      = tg_x;
        s1_d.y      = tg_y;
        s1_d.cph    = tg_cph;
        s1_d.mode   = mode_e'(MODE_i);
        s1_d.fctr   = tg_fctr;
        leds_d      = LEDs_ON_i;
    end

    // stage 2: LED hit and palette read (squares never overlap)
    always_comb begin
        s2_d        = '0;
        s2_d.sync   = s1_q.sync;
        s2_d.burst  = s1_q.burst;
        s2_d.active = s1_q.active;
        s2_d.cph    = s1_q.cph;
        s2_d.mode   = s1_q.mode;
        s2_d.ramp   = 3'((s1_q.x[7:0] + s1_q.y + s1_q.fctr) >> 5);
        s2_d.bar    = 3'(s1_q.x / 9'(BAR_W));
        for (int n = 0; n < C_LED_N; n++) begin
            if (leds_q[n] && in_square(s1_q.x, s1_q.y, n)) begin
                s2_d.hit = 1'b1;
                s2_d.pal = pal_q[n];
            end
        end
    end

    // stage 3: luma selection, phase add and sine lookup
    always_comb begin
        luma_d   = SW'(C_PEDE);
        chroma_d = '0;
        if (s2_q.sync) begin
            luma_d = '0;
        end else if (s2_q.burst) begin
            chroma_d = SW'(sin_lut(s2_q.cph + 3'(BURST_OFS), C_CAMP));
        end else if (s2_q.active) begin
            case (s2_q.mode)
                MODE_GRID: begin
                    if (s2_q.hit) begin
                        luma_d = SW'(C_PEDE + C_WHITE);
                        if (s2_q.pal[3]) begin
                            chroma_d = SW'(sin_lut(s2_q.cph + s2_q.pal[2:0], C_CAMP));
                        end
                    end
                end
                MODE_RAMP: luma_d = SW'(C_PEDE + 4 * int'(s2_q.ramp));
                MODE_BARS: begin
                    luma_d = SW'(C_PEDE + C_WHITE / 2);
                    if (s2_q.bar != 3'd0) begin
                        chroma_d = SW'(sin_lut(s2_q.cph + s2_q.bar, C_CAMP));
                    end
                end
                default: ;
            endcase
        end
    end

    // stage 4: signed sum and clamp to the DAC range
    always_comb begin
        sum_s = signed'(luma_q) + chroma_q;
        if (sum_s[SW-1]) begin
            video_d = '0;
        end else if (|sum_s[SW-2:C_DAC_W]) begin
            video_d = '1;
        end else begin
            video_d = sum_s[C_DAC_W-1:0];
        end
    end

    // flushed pipeline: inactive flags make stage 3 emit pedestal
    always_ff @(posedge CK_i) begin
        if (RST_i) begin
            s1_q     <= '0;
            leds_q   <= '0;
            s2_q     <= '0;
            luma_q   <= SW'(C_PEDE);
            chroma_q <= '0;
            video_q  <= C_DAC_W'(C_PEDE);
            for (int n = 0; n < C_LED_N; n++) begin
                pal_q[n] <= '0;
            end
        end else if (CK_EE_i) begin
            s1_q     <= s1_d;
            leds_q   <= leds_d;
            s2_q     <= s2_d;
            luma_q   <= luma_d;
            chroma_q <= chroma_d;
            video_q  <= video_d;
            for (int n = 0; n < C_LED_N; n++) begin
                pal_q[n] <= pal_d[n];
            end
        end
    end

    assign VIDEOs_o = video_q;
    assign FCTRs_o  = tg_fctr;

endmodule
